mos_microseq_decoder: RTL and testbench

//  Parametrised microcoded decoder for the MOSby 6502-style core. It latches the fetched opcode,

---
 rtl/mos_pkg.sv | 71 +++++++
 rtl/mos_microseq_decoder_if.sv | 41 ++++
 rtl/mos_ucode_rom.sv | 92 +++++++++
 rtl/mos_microseq_decoder.sv | 99 +++++++++
 tb/tb_mos_microseq_decoder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mos_pkg.sv
// Shared types for the MOSby micro-sequenced decoder: ALU/branch encodings,
// supported opcodes and the per-cycle control word.
package mos_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADC  = 4'd1,
    ALU_SBC  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_EOR  = 4'd4,
    ALU_ORA  = 4'd5,
    ALU_BIT  = 4'd6,
    ALU_ASL  = 4'd7,
    ALU_LSR  = 4'd8,
    ALU_ROL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2
  } branch_op_e;

  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_AND_IMM = 8'h29;
  localparam logic [7:0] OP_ORA_IMM = 8'h09;
  localparam logic [7:0] OP_EOR_IMM = 8'h49;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_ADC_ZP  = 8'h65;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_ADC_ABS = 8'h6D;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_BEQ     = 8'hF0;
  localparam logic [7:0] OP_BNE     = 8'hD0;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  typedef struct packed {
    logic       w_rd;
    logic       pc_data;
    logic       increment;
    logic       lower_byte;
    logic       x_con;
    logic       y_con;
    logic       accumulator_con;
    logic       status_con;
    logic       stack_pointer_con;
    alu_op_e    alu_op;
    branch_op_e branch_op;
    logic       branch_uncon;
    logic       branch_con;
    logic       fetch;
    logic       last;
  } ctrl_t;

  // ALU operation applied when an accumulator-loading opcode writes A.
  function automatic alu_op_e acc_alu_op(input logic [7:0] op);
    case (op)
      OP_ADC_IMM, OP_ADC_ZP, OP_ADC_ABS: acc_alu_op = ALU_ADC;
      OP_AND_IMM:                        acc_alu_op = ALU_AND;
      OP_ORA_IMM:                        acc_alu_op = ALU_ORA;
      OP_EOR_IMM:                        acc_alu_op = ALU_EOR;
      OP_SBC_IMM:                        acc_alu_op = ALU_SBC;
      default:                           acc_alu_op = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mos_microseq_decoder_if.sv
// Bus between the instruction side / datapath and the decoder: stall, flush,
// fetched byte in; control word and sequencing status out.
interface mos_microseq_decoder_if #(
  parameter int STEP_W = 3
);
  logic              normal;
  logic              flush;
  logic [7:0]        instruction;

  logic              w_rd;
  logic              pc_data;
  logic              increment;
  logic              lower_byte;
  logic              x_con;
  logic              y_con;
  logic              accumulator_con;
  logic              status_con;
  logic              stack_pointer_con;
  logic [3:0]        alu_op;
  logic [2:0]        branch_op;
  logic              branch_uncon;
  logic              branch_con;
  logic [STEP_W-1:0] step;
  logic              fetch;
  logic              last_step;
  logic              illegal;

  modport master (
    output normal, flush, instruction,
    input  w_rd, pc_data, increment, lower_byte, x_con, y_con, accumulator_con,
           status_con, stack_pointer_con, alu_op, branch_op, branch_uncon,
           branch_con, step, fetch, last_step, illegal
  );

  modport slave (
    input  normal, flush, instruction,
    output w_rd, pc_data, increment, lower_byte, x_con, y_con, accumulator_con,
           status_con, stack_pointer_con, alu_op, branch_op, branch_uncon,
           branch_con, step, fetch, last_step, illegal
  );
endinterface

// File: rtl/mos_ucode_rom.sv
// Combinational microcode table: (opcode, micro-step) -> control word, plus a
// flag for unknown opcodes or steps past the end of an instruction.
module mos_ucode_rom
  import mos_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 1,
  parameter int STEP_W       = 3
) (
  input  logic [7:0]        i_ir,
  input  logic [STEP_W-1:0] i_step,
  output ctrl_t             o_cw,
  output logic              o_bad
);

  localparam logic [STEP_W-1:0] S0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] S1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] S2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] S3 = STEP_W'(3);

  logic w_over;

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    o_cw   = '0;
    o_bad  = 1'b0;
    w_over = 1'b0;
    if (i_step == S0) begin
      o_cw.pc_data   = 1'b1;
      o_cw.increment = 1'b1;
      o_cw.fetch     = 1'b1;
    end else begin
      case (i_ir)
        OP_ADC_IMM, OP_AND_IMM, OP_ORA_IMM, OP_EOR_IMM, OP_SBC_IMM, OP_LDA_IMM: begin
          if (i_step == S1) begin
            o_cw.pc_data         = 1'b1;
            o_cw.increment       = 1'b1;
            o_cw.accumulator_con = 1'b1;
            o_cw.status_con      = 1'b1;
            o_cw.alu_op          = acc_alu_op(i_ir);
            o_cw.last            = 1'b1;
          end else w_over = 1'b1;
        end
        OP_ADC_ZP, OP_LDA_ZP, OP_ADC_ABS, OP_LDA_ABS, OP_JMP_ABS: begin
          // Operand bytes follow the opcode; the first one is the low address byte.
          if (i_step == S1) begin
            o_cw.pc_data    = 1'b1;
            o_cw.increment  = 1'b1;
            o_cw.lower_byte = 1'b1;
          end else if (i_step == S2 && i_ir == OP_JMP_ABS) begin
            o_cw.pc_data      = 1'b1;
            o_cw.branch_uncon = 1'b1;
            o_cw.last         = 1'b1;
          end else if (i_step == S2 && (i_ir == OP_ADC_ABS || i_ir == OP_LDA_ABS)) begin
            o_cw.pc_data   = 1'b1;
            o_cw.increment = 1'b1;
          end else if ((i_step == S2 && (i_ir == OP_ADC_ZP || i_ir == OP_LDA_ZP)) ||
                       (i_step == S3 && (i_ir == OP_ADC_ABS || i_ir == OP_LDA_ABS))) begin
            o_cw.accumulator_con = 1'b1;
            o_cw.status_con      = 1'b1;
            o_cw.alu_op          = acc_alu_op(i_ir);
            o_cw.last            = 1'b1;
          end else w_over = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          if (i_step == S1) begin
            o_cw.pc_data    = 1'b1;
            o_cw.increment  = 1'b1;
            o_cw.branch_con = 1'b1;
            o_cw.branch_op  = (i_ir == OP_BEQ) ? BR_EQ : BR_NE;
            o_cw.last       = 1'b1;
          end else w_over = 1'b1;
        end
        OP_NOP: begin
          if (i_step == S1) o_cw.last = 1'b1;
          else              w_over    = 1'b1;
        end
        default: begin
          if (i_step == S1) begin
            o_bad     = 1'b1;
            o_cw.last = (ILLEGAL_TRAP == 0);
          end else w_over = 1'b1;
        end
      endcase
    end
    // A step beyond the end of any instruction ends it and flags the anomaly.
    if (w_over) begin
      o_cw.last = 1'b1;
      o_bad     = 1'b1;
    end
  end

endmodule

// File: rtl/mos_microseq_decoder.sv
// Micro-sequenced opcode decoder: owns IR, the micro-step counter and the
// illegal-opcode trap, and gates the microcode control word for stall/reset.
module mos_microseq_decoder
  import mos_pkg::*;
#(
  parameter int         MAX_STEPS    = 8,
  parameter int         STEP_W       = 3,
  parameter int         ILLEGAL_TRAP = 1,
  parameter logic [7:0] RESET_IR     = 8'hEA
) (
  input logic                  clk_2,
  input logic                  rst,
  mos_microseq_decoder_if.slave bus
);

  logic [7:0]        r_ir;
  logic [STEP_W-1:0] r_step;
  logic              r_trap;

  ctrl_t w_cw;
  logic  w_bad;
  logic  w_guard;

  mos_ucode_rom #(
    .ILLEGAL_TRAP (ILLEGAL_TRAP),
    .STEP_W       (STEP_W)
  ) u_rom (
    .i_ir   (r_ir),
    .i_step (r_step),
    .o_cw   (w_cw),
    .o_bad  (w_bad)
  );

  // Safety net: a microprogram that reaches the last counter slot without ending is aborted.
  assign w_guard = (r_step == STEP_W'(MAX_STEPS - 1)) && !w_cw.last && !r_trap;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_2) begin
    if (rst || bus.flush) begin
      r_step <= '0;
      r_ir   <= RESET_IR;
      r_trap <= 1'b0;
    end else if (bus.normal && !r_trap) begin
      if (r_step == '0) begin
        r_ir   <= bus.instruction;
        r_step <= STEP_W'(1);
      end else if (w_cw.last || w_guard) begin
        r_step <= '0;
      end else if (w_bad && (ILLEGAL_TRAP != 0)) begin
        r_trap <= 1'b1;
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  always_comb begin
    bus.w_rd              = 1'b0;
    bus.pc_data           = 1'b0;
    bus.increment         = 1'b0;
    bus.lower_byte        = 1'b0;
    bus.x_con             = 1'b0;
    bus.y_con             = 1'b0;
    bus.accumulator_con   = 1'b0;
    bus.status_con        = 1'b0;
    bus.stack_pointer_con = 1'b0;
    bus.alu_op            = 4'd0;
    bus.branch_op         = 3'd0;
    bus.branch_uncon      = 1'b0;
    bus.branch_con        = 1'b0;
    bus.fetch             = 1'b0;
    bus.last_step         = 1'b0;
    bus.illegal           = 1'b0;
    bus.step              = rst ? '0 : r_step;
    if (!rst && bus.normal) begin
      if (r_trap) begin
        bus.illegal = 1'b1;
      end else begin
        bus.w_rd              = w_cw.w_rd;
        bus.pc_data           = w_cw.pc_data;
        bus.increment         = w_cw.increment;
        bus.lower_byte        = w_cw.lower_byte;
        bus.x_con             = w_cw.x_con;
        bus.y_con             = w_cw.y_con;
        bus.accumulator_con   = w_cw.accumulator_con;
        bus.status_con        = w_cw.status_con;
        bus.stack_pointer_con = w_cw.stack_pointer_con;
        bus.alu_op            = w_cw.alu_op;
        bus.branch_op         = w_cw.branch_op;
        bus.branch_uncon      = w_cw.branch_uncon;
        bus.branch_con        = w_cw.branch_con;
        bus.fetch             = w_cw.fetch;
        bus.last_step         = w_cw.last;
        bus.illegal           = w_bad | w_guard;
      end
    end
  end

endmodule

// File: tb/tb_mos_microseq_decoder.sv
// Bench for mos_microseq_decoder: trap and non-trap instances side by side,
// directed scenarios then random traffic against an instruction-class model.
module tb_mos_microseq_decoder;

  typedef struct packed {
    logic       w_rd, pc, inc, lb, x, y, acc, st, sp;
    logic [3:0] alu;
    logic [2:0] bop;
    logic       bu, bc, fetch, last, ill;
    logic [2:0] step;
  } obs_t;

  typedef enum int {C_IMM, C_ZP, C_ABS, C_JMP, C_BR, C_NOP, C_BAD} cls_e;

  logic clk_2 = 1'b0;
  logic rst;
  always #5 clk_2 = ~clk_2;

  mos_microseq_decoder_if #(.STEP_W(3)) bus0 ();
  mos_microseq_decoder_if #(.STEP_W(3)) bus1 ();

  mos_microseq_decoder #(.MAX_STEPS(8), .STEP_W(3), .ILLEGAL_TRAP(1), .RESET_IR(8'hEA))
    u_trap (.clk_2(clk_2), .rst(rst), .bus(bus0));
  mos_microseq_decoder #(.MAX_STEPS(8), .STEP_W(3), .ILLEGAL_TRAP(0), .RESET_IR(8'hEA))
    u_notrap (.clk_2(clk_2), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic       cur_rst, cur_flush, cur_normal;
  logic [7:0] cur_ins;
  logic [7:0] m_op   [2];
  int         m_pos  [2];
  bit         m_trap [2];

  localparam logic [7:0] OPS [16] = '{8'h69, 8'h29, 8'h09, 8'h49, 8'hE9, 8'hA9, 8'h65, 8'hA5,
                                     8'h6D, 8'hAD, 8'h4C, 8'hF0, 8'hD0, 8'hEA, 8'h02, 8'hFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic cls_e cls_of(input logic [7:0] op);
    case (op)
      8'h69, 8'h29, 8'h09, 8'h49, 8'hE9, 8'hA9: return C_IMM;
      8'h65, 8'hA5: return C_ZP;
      8'h6D, 8'hAD: return C_ABS;
      8'h4C:        return C_JMP;
      8'hF0, 8'hD0: return C_BR;
      8'hEA:        return C_NOP;
      default:      return C_BAD;
    endcase
  endfunction

  function automatic int len_of(input cls_e c);
    case (c)
      C_ZP, C_JMP: return 2;
      C_ABS:       return 3;
      default:     return 1;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [7:0] op);
    case (op)
      8'h69, 8'h65, 8'h6D: return 4'd1;
      8'hE9:               return 4'd2;
      8'h29:               return 4'd3;
      8'h49:               return 4'd4;
      8'h09:               return 4'd5;
      default:             return 4'd11;
    endcase
  endfunction

  // Expected outputs from the instruction's class and its position in the sequence.
  function automatic obs_t exp_of(input int d);
    obs_t e = '0;
    cls_e c;
    int   len, k;
    if (cur_rst) return e;
    e.step = m_trap[d] ? 3'd1 : 3'(m_pos[d]);
    if (!cur_normal) return e;
    if (m_trap[d]) begin e.ill = 1'b1; return e; end
    if (m_pos[d] == 0) begin e.pc = 1'b1; e.inc = 1'b1; e.fetch = 1'b1; return e; end
    c   = cls_of(m_op[d]);
    len = len_of(c);
    k   = m_pos[d];
    e.last = (k == len) && !(c == C_BAD && d == 0);
    if (k < len) begin
      e.pc = 1'b1; e.inc = 1'b1; e.lb = (k == 1);
    end else begin
      case (c)
        C_IMM:       begin e.pc = 1'b1; e.inc = 1'b1; e.acc = 1'b1; e.st = 1'b1; e.alu = alu_of(m_op[d]); end
        C_ZP, C_ABS: begin e.acc = 1'b1; e.st = 1'b1; e.alu = alu_of(m_op[d]); end
        C_JMP:       begin e.pc = 1'b1; e.bu = 1'b1; end
        C_BR:        begin e.pc = 1'b1; e.inc = 1'b1; e.bc = 1'b1; e.bop = (m_op[d] == 8'hF0) ? 3'd1 : 3'd2; end
        C_BAD:       e.ill = 1'b1;
        default:     ;
      endcase
    end
    return e;
  endfunction

  function automatic obs_t obs(input int d);
    if (d == 0)
      return obs_t'({bus0.w_rd, bus0.pc_data, bus0.increment, bus0.lower_byte, bus0.x_con, bus0.y_con,
                     bus0.accumulator_con, bus0.status_con, bus0.stack_pointer_con, bus0.alu_op,
                     bus0.branch_op, bus0.branch_uncon, bus0.branch_con, bus0.fetch, bus0.last_step,
                     bus0.illegal, bus0.step});
    return obs_t'({bus1.w_rd, bus1.pc_data, bus1.increment, bus1.lower_byte, bus1.x_con, bus1.y_con,
                   bus1.accumulator_con, bus1.status_con, bus1.stack_pointer_con, bus1.alu_op,
                   bus1.branch_op, bus1.branch_uncon, bus1.branch_con, bus1.fetch, bus1.last_step,
                   bus1.illegal, bus1.step});
  endfunction

  task automatic model_update(input int d);
    if (cur_rst || cur_flush) begin
      m_pos[d] = 0; m_op[d] = 8'hEA; m_trap[d] = 1'b0;
    end else if (cur_normal && !m_trap[d]) begin
      if (m_pos[d] == 0) begin
        m_op[d] = cur_ins; m_pos[d] = 1;
      end else if (cls_of(m_op[d]) == C_BAD && d == 0) begin
        m_trap[d] = 1'b1;
      end else if (m_pos[d] == len_of(cls_of(m_op[d]))) begin
        m_pos[d] = 0;
      end else begin
        m_pos[d]++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic n, input logic [7:0] ins);
    @(negedge clk_2);
    rst = r;
    bus0.flush = f; bus0.normal = n; bus0.instruction = ins;
    bus1.flush = f; bus1.normal = n; bus1.instruction = ins;
    cur_rst = r; cur_flush = f; cur_normal = n; cur_ins = ins;
    #1;
    check("cw_trap",   32'(obs(0)), 32'(exp_of(0)));
    check("cw_notrap", 32'(obs(1)), 32'(exp_of(1)));
  endtask

  task automatic tick();
    @(posedge clk_2);
    model_update(0);
    model_update(1);
  endtask

  initial begin
    logic r, f, n;
    logic [7:0] ins;
    m_pos = '{0, 0}; m_trap = '{1'b0, 1'b0}; m_op = '{8'hEA, 8'hEA};

    repeat (2) begin
      drive(1'b1, 1'b0, 1'b1, 8'h69);
      check("rst_step", 32'(bus0.step), 32'd0);
      tick();
    end

    drive(1'b0, 1'b0, 1'b1, 8'h69);
    check("first_fetch", 32'({bus0.fetch, bus0.pc_data, bus0.increment}), 32'h7);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h05);
    check("imm_ctrl", 32'({bus0.accumulator_con, bus0.status_con, bus0.increment, bus0.last_step}), 32'hF);
    check("imm_alu", 32'(bus0.alu_op), 32'd1);
    tick();

    drive(1'b0, 1'b0, 1'b1, 8'hAD);
    check("imm_done_step", 32'(bus0.step), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    check("abs_s1_lb", 32'(bus0.lower_byte), 32'd1);
    tick();
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b0, 8'h20);
      check("stall_step", 32'(bus0.step), 32'd2);
      check("stall_inc", 32'(bus0.increment), 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 8'h20);
    check("abs_s2_inc", 32'(bus0.increment), 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h55);
    check("abs_s3", 32'({bus0.pc_data, bus0.alu_op, bus0.accumulator_con}), 32'({1'b0, 4'd11, 1'b1}));
    tick();

    drive(1'b0, 1'b0, 1'b1, 8'h4C);
    tick();
    drive(1'b0, 1'b1, 1'b1, 8'h34);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'hEA);
    check("jmp_flush", 32'({bus0.step, bus0.fetch, bus0.branch_uncon}), 32'({3'd0, 1'b1, 1'b0}));
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h4C);
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'h12);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h02);
    check("stall_flush", 32'({bus0.step, bus0.fetch, bus0.branch_uncon}), 32'({3'd0, 1'b1, 1'b0}));
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'hEA);
      check("trap_held", 32'({bus0.illegal, bus0.step}), 32'({1'b1, 3'd1}));
      if (i == 0) check("notrap_pulse", 32'({bus1.illegal, bus1.last_step}), 32'h3);
      if (i == 1) check("notrap_fetch", 32'({bus1.illegal, bus1.fetch}), 32'h1);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 8'hEA);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'hEA);
    check("trap_cleared", 32'({bus0.illegal, bus0.fetch, bus0.step}), 32'({1'b0, 1'b1, 3'd0}));
    tick();

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(99) < 2);
      f   = ($urandom_range(99) < 5);
      n   = ($urandom_range(99) < 80);
      ins = ($urandom_range(3) != 0) ? OPS[$urandom_range(15)] : 8'($urandom);
      drive(r, f, n, ins);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
